// File: rtl/enemy_collision_director.sv
// enemy_collision_director: zero-latency wall/dodge/hit strobes plus per-enemy HP, cooldown and alive bookkeeping.
// Define ENEMY_RESPAWN_EN to bring dead enemies back after RESPAWN_FRAMES unpaused frames.
module enemy_collision_director #(
   parameter int AMOUNT_OF_ENEMIES     = 2,
   parameter int ENEMY_HP              = 3,
   parameter int DODGE_COOLDOWN_FRAMES = 4,
   parameter int RESPAWN_FRAMES        = 60
) (
   input  logic                         clk,
   input  logic                         resetN,
   input  logic                         startOfFrame,
   input  logic                         pause,
   input  logic                         enemyDrawReq,
   input  logic                         headsUpDrawReq,
   input  logic                         headsDownDrawReq,
   input  logic [3:0]                   drawingRequestorId,
   input  logic                         wallDrawReq,
   input  logic                         playerBulletDrawReq,
   input  logic [2:0]                   bulletDamage,
   output logic                         changeDir,
   output logic                         dodgeBullet,
   output logic [2:0]                   shotCollision,
   output logic [AMOUNT_OF_ENEMIES-1:0] aliveMap,
   output logic [7:0]                   killCount,
   output logic                         allKilled
);
   localparam int N = AMOUNT_OF_ENEMIES;
   logic [N-1:0] dir_done, dodge_done, hit_done, sel;
   logic [3:0] cool [N];
   logic [2:0] hp [N];
   logic [2:0] dmg, hp_sel;
   logic v, dir_sel, dodge_sel, hit_sel, cool_zero, kill;
`ifdef ENEMY_RESPAWN_EN
   logic [15:0] resp [N];
`endif
   // Mux the requesting enemy's state; an out-of-range id matches nobody and leaves v low.
   always_comb begin
      sel = '0;
      v = 1'b0;
      dir_sel = 1'b0;
      dodge_sel = 1'b0;
      hit_sel = 1'b0;
      cool_zero = 1'b0;
      hp_sel = '0;
      for (int i = 0; i < N; i++) begin
         sel[i] = 4'(i) == drawingRequestorId;
         if (sel[i]) begin
            v = aliveMap[i];
            dir_sel = dir_done[i];
            dodge_sel = dodge_done[i];
            hit_sel = hit_done[i];
            cool_zero = cool[i] == 4'd0;
            hp_sel = hp[i];
         end
      end
      v = v && !pause && !resetN;
      dmg = bulletDamage == 3'd0 ? 3'd1 : bulletDamage;
      changeDir = v && enemyDrawReq && wallDrawReq && !dir_sel;
      dodgeBullet = v && (headsUpDrawReq || headsDownDrawReq) && playerBulletDrawReq && !enemyDrawReq && !dodge_sel && cool_zero;
      shotCollision = (v && enemyDrawReq && playerBulletDrawReq && !hit_sel) ? dmg : 3'd0;
      kill = shotCollision != 3'd0 && hp_sel <= dmg;
   end
   always_ff @(posedge clk) begin
      if (resetN) begin
         aliveMap <= '1;
         dir_done <= '0;
         dodge_done <= '0;
         hit_done <= '0;
         killCount <= 8'd0;
         allKilled <= 1'b0;
         for (int i = 0; i < N; i++) begin
            hp[i] <= 3'(ENEMY_HP);
            cool[i] <= 4'd0;
`ifdef ENEMY_RESPAWN_EN
            resp[i] <= 16'd0;
`endif
         end
      end else begin
         allKilled <= aliveMap == '0;
         if (kill && killCount != 8'hff) killCount <= killCount + 8'd1;
         for (int i = 0; i < N; i++) begin
            // A flag raised in the frame-start cycle survives the clear.
            dir_done[i] <= (sel[i] && changeDir) || (dir_done[i] && !startOfFrame);
            dodge_done[i] <= (sel[i] && dodgeBullet) || (dodge_done[i] && !startOfFrame);
            hit_done[i] <= (sel[i] && shotCollision != 3'd0) || (hit_done[i] && !startOfFrame);
            if (sel[i] && dodgeBullet) cool[i] <= 4'(DODGE_COOLDOWN_FRAMES);
            else if (startOfFrame && !pause && cool[i] != 4'd0) cool[i] <= cool[i] - 4'd1;
            if (sel[i] && shotCollision != 3'd0) hp[i] <= hp[i] > dmg ? hp[i] - dmg : 3'd0;
            if (sel[i] && kill) begin
               aliveMap[i] <= 1'b0;
`ifdef ENEMY_RESPAWN_EN
               resp[i] <= 16'(RESPAWN_FRAMES);
`endif
            end
`ifdef ENEMY_RESPAWN_EN
            if (!aliveMap[i] && !pause && resp[i] == 16'd0) begin
               aliveMap[i] <= 1'b1;
               hp[i] <= 3'(ENEMY_HP);
               dir_done[i] <= 1'b0;
               dodge_done[i] <= 1'b0;
               hit_done[i] <= 1'b0;
               cool[i] <= 4'd0;
            end else if (!aliveMap[i] && startOfFrame && !pause && resp[i] != 16'd0) resp[i] <= resp[i] - 16'd1;
`endif
         end
      end
   end
endmodule

// File: tb/tb_enemy_collision_director.sv
// tb_enemy_collision_director: directed vectors with hand-computed expectations for enemy_collision_director.
module tb_enemy_collision_director;
   logic clk = 1'b0;
   logic resetN, startOfFrame, pause, enemyDrawReq, headsUpDrawReq, headsDownDrawReq;
   logic wallDrawReq, playerBulletDrawReq, changeDir, dodgeBullet, allKilled;
   logic [3:0] drawingRequestorId;
   logic [2:0] bulletDamage, shotCollision;
   logic [1:0] aliveMap;
   logic [7:0] killCount;
   int checks = 0;
   int failures = 0;
   enemy_collision_director #(
      .AMOUNT_OF_ENEMIES(2), .ENEMY_HP(3), .DODGE_COOLDOWN_FRAMES(4), .RESPAWN_FRAMES(2)
   ) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pause(pause),
      .enemyDrawReq(enemyDrawReq), .headsUpDrawReq(headsUpDrawReq), .headsDownDrawReq(headsDownDrawReq),
      .drawingRequestorId(drawingRequestorId), .wallDrawReq(wallDrawReq),
      .playerBulletDrawReq(playerBulletDrawReq), .bulletDamage(bulletDamage),
      .changeDir(changeDir), .dodgeBullet(dodgeBullet), .shotCollision(shotCollision),
      .aliveMap(aliveMap), .killCount(killCount), .allKilled(allKilled)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // Apply one cycle of inputs on the falling edge; comb outputs are checked right after.
   task automatic drive(input int id, input int e, input int hu, input int hd, input int w, input int b, input int d, input int s, input int p);
      @(negedge clk);
      drawingRequestorId = 4'(id);
      enemyDrawReq = 1'(e);
      headsUpDrawReq = 1'(hu);
      headsDownDrawReq = 1'(hd);
      wallDrawReq = 1'(w);
      playerBulletDrawReq = 1'(b);
      bulletDamage = 3'(d);
      startOfFrame = 1'(s);
      pause = 1'(p);
      #1;
   endtask
   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic frame();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
   endtask
   initial begin
      resetN = 1'b1;
      startOfFrame = 1'b0;
      pause = 1'b0;
      enemyDrawReq = 1'b0;
      headsUpDrawReq = 1'b0;
      headsDownDrawReq = 1'b0;
      drawingRequestorId = 4'd0;
      wallDrawReq = 1'b0;
      playerBulletDrawReq = 1'b0;
      bulletDamage = 3'd0;
      repeat (2) @(negedge clk);
      drive(1, 1, 1, 1, 1, 1, 7, 0, 0);
      check("rst_cd", 8'(changeDir), 8'd0);
      check("rst_shot", 8'(shotCollision), 8'd0);
      check("rst_alive", 8'(aliveMap), 8'd3);
      check("rst_kills", killCount, 8'd0);
      check("rst_allk", 8'(allKilled), 8'd0);
      idle();
      resetN = 1'b0;
      // Wall bounce: once per frame.
      drive(1, 1, 0, 0, 1, 0, 0, 0, 0);
      check("wall_first", 8'(changeDir), 8'd1);
      check("wall_noshot", 8'(shotCollision), 8'd0);
      drive(1, 1, 0, 0, 1, 0, 0, 0, 0);
      check("wall_second", 8'(changeDir), 8'd0);
      drive(1, 1, 0, 0, 1, 0, 0, 0, 0);
      check("wall_third", 8'(changeDir), 8'd0);
      frame();
      drive(1, 1, 0, 0, 1, 0, 0, 0, 0);
      check("wall_newframe", 8'(changeDir), 8'd1);
`ifdef ENEMY_RESPAWN_EN
      frame();
      drive(0, 1, 0, 0, 0, 1, 7, 0, 0);
      check("rs_kill_shot", 8'(shotCollision), 8'd7);
      idle();
      check("rs_dead", 8'(aliveMap), 8'd2);
      check("rs_kills", killCount, 8'd1);
      frame();
      frame();
      idle();
      check("rs_still_dead", 8'(aliveMap), 8'd2);
      idle();
      check("rs_back", 8'(aliveMap), 8'd3);
      check("rs_kills_kept", killCount, 8'd1);
      drive(0, 1, 0, 0, 0, 1, 2, 0, 0);
      check("rs_hit2", 8'(shotCollision), 8'd2);
      idle();
      check("rs_hp_restored", 8'(aliveMap), 8'd3);
      frame();
      drive(0, 1, 0, 0, 0, 1, 2, 0, 0);
      check("rs_hit2b", 8'(shotCollision), 8'd2);
      idle();
      check("rs_dead_again", 8'(aliveMap), 8'd2);
      check("rs_kills2", killCount, 8'd2);
`else
      // Three single-damage hits (damage 0 counts as 1) kill enemy 0.
      for (int k = 0; k < 3; k++) begin
         frame();
         drive(0, 1, 0, 0, 0, 1, 0, 0, 0);
         check("hit_once", 8'(shotCollision), 8'd1);
         drive(0, 1, 0, 0, 0, 1, 0, 0, 0);
         check("hit_repeat", 8'(shotCollision), 8'd0);
      end
      idle();
      check("kill_alive", 8'(aliveMap), 8'd2);
      check("kill_count", killCount, 8'd1);
      check("kill_allk", 8'(allKilled), 8'd0);
      frame();
      drive(0, 1, 0, 0, 1, 1, 0, 0, 0);
      check("dead_shot", 8'(shotCollision), 8'd0);
      check("dead_cd", 8'(changeDir), 8'd0);
      // Flag set in the frame-start cycle wins over the clear.
      frame();
      drive(1, 1, 0, 0, 1, 0, 0, 1, 0);
      check("sof_set_cd", 8'(changeDir), 8'd1);
      drive(1, 1, 0, 0, 1, 0, 0, 0, 0);
      check("sof_set_wins", 8'(changeDir), 8'd0);
      // Dodge fired in a frame-start cycle: frames 1-4 blocked, frame 5 allowed.
      drive(1, 0, 1, 0, 0, 1, 0, 1, 0);
      check("dodge_first", 8'(dodgeBullet), 8'd1);
      drive(1, 0, 1, 0, 0, 1, 0, 0, 0);
      check("dodge_f1", 8'(dodgeBullet), 8'd0);
      for (int f = 2; f <= 4; f++) begin
         frame();
         drive(1, 0, 0, 1, 0, 1, 0, 0, 0);
         check("dodge_cool", 8'(dodgeBullet), 8'd0);
      end
      frame();
      drive(1, 1, 1, 0, 0, 1, 0, 0, 0);
      check("override_dodge", 8'(dodgeBullet), 8'd0);
      check("override_shot", 8'(shotCollision), 8'd1);
      drive(1, 0, 0, 1, 0, 1, 0, 0, 0);
      check("dodge_f5", 8'(dodgeBullet), 8'd1);
      // Pause blocks everything and freezes the cooldown.
      frame();
      drive(1, 1, 0, 0, 1, 1, 0, 0, 1);
      check("pause_cd", 8'(changeDir), 8'd0);
      check("pause_shot", 8'(shotCollision), 8'd0);
      drive(1, 1, 0, 0, 1, 1, 0, 0, 1);
      check("pause_shot2", 8'(shotCollision), 8'd0);
      drive(1, 0, 1, 0, 1, 1, 0, 1, 1);
      check("pause_dodge", 8'(dodgeBullet), 8'd0);
      frame();
      drive(1, 1, 0, 0, 1, 1, 0, 0, 0);
      check("resume_cd", 8'(changeDir), 8'd1);
      check("resume_shot", 8'(shotCollision), 8'd1);
      idle();
      check("pause_hp_kept", 8'(aliveMap), 8'd2);
      frame();
      drive(1, 0, 1, 0, 0, 1, 0, 0, 0);
      check("pause_cool_frozen", 8'(dodgeBullet), 8'd0);
      frame();
      drive(1, 0, 1, 0, 0, 1, 0, 0, 0);
      check("cool_expired", 8'(dodgeBullet), 8'd1);
      // Out-of-range id, then the last enemy dies.
      drive(5, 1, 1, 1, 1, 1, 7, 0, 0);
      check("oor_cd", 8'(changeDir), 8'd0);
      check("oor_dodge", 8'(dodgeBullet), 8'd0);
      check("oor_shot", 8'(shotCollision), 8'd0);
      idle();
      check("oor_alive", 8'(aliveMap), 8'd2);
      check("oor_kills", killCount, 8'd1);
      frame();
      drive(1, 1, 0, 0, 0, 1, 7, 0, 0);
      check("kill7_shot", 8'(shotCollision), 8'd7);
      idle();
      check("all_dead_map", 8'(aliveMap), 8'd0);
      check("allk_lag", 8'(allKilled), 8'd0);
      check("kill_count2", killCount, 8'd2);
      idle();
      check("allk_set", 8'(allKilled), 8'd1);
      drive(1, 1, 0, 0, 1, 1, 7, 0, 0);
      check("all_dead_cd", 8'(changeDir), 8'd0);
      check("all_dead_shot", 8'(shotCollision), 8'd0);
`endif
      // Mid-frame reset reinitialises everything.
      idle();
      resetN = 1'b1;
      drive(1, 1, 0, 0, 1, 1, 0, 0, 0);
      check("mid_rst_shot", 8'(shotCollision), 8'd0);
      check("mid_rst_cd", 8'(changeDir), 8'd0);
      check("mid_rst_alive", 8'(aliveMap), 8'd3);
      check("mid_rst_kills", killCount, 8'd0);
      check("mid_rst_allk", 8'(allKilled), 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/enemy_collision_director.md
Name: enemy_collision_director

Overview:
Upstream event generator for the enemy stock manager. Watches the per-pixel draw-request stream (enemy body, heads-up/heads-down zones, requestor id) alongside wall and player-bullet draw requests, and produces the changeDir, dodgeBullet and shotCollision strobes the stock manager routes to individual enemies. Holds per-enemy once-per-frame event flags, dodge cooldowns, hit points, alive map and kill count.

Parameters:
AMOUNT_OF_ENEMIES, 2, number of enemies tracked (1..16)
ENEMY_HP, 3, initial hit points per enemy (1..7)
DODGE_COOLDOWN_FRAMES, 4, frames an enemy must wait after a dodge before it may dodge again (0..15)
RESPAWN_FRAMES, 60, frames before a dead enemy respawns (used only with ENEMY_RESPAWN_EN)

Ports:
clk  in  1  system clock
resetN  in  1  synchronous reset, active-high (asserted = 1); sampled on rising clk
startOfFrame  in  1  one-cycle pulse at frame start
pause  in  1  freeze game events
enemyDrawReq  in  1  enemy body pixel active
headsUpDrawReq  in  1  heads-up zone pixel active
headsDownDrawReq  in  1  heads-down zone pixel active
drawingRequestorId  in  4  enemy index owning the current request
wallDrawReq  in  1  side-wall pixel active
playerBulletDrawReq  in  1  player bullet pixel active
bulletDamage  in  3  damage carried by current bullet; 0 treated as 1
changeDir  out  1  combinational strobe: enemy hit a wall
dodgeBullet  out  1  combinational strobe: bullet entered a heads zone
shotCollision  out  3  combinational: applied damage, 0 = no hit
aliveMap  out  AMOUNT_OF_ENEMIES  registered, bit i = enemy i alive
killCount  out  8  registered kills, saturating
allKilled  out  1  registered, aliveMap == 0

Behaviour:
- Reset (resetN=1 at clock edge): aliveMap all ones, HP[i]=ENEMY_HP, all frame flags and cooldowns 0, killCount=0, allKilled=0. Combinational outputs are 0 in reset cycles.
- Valid id: v = (drawingRequestorId < AMOUNT_OF_ENEMIES) && aliveMap[id] && !pause && !resetN. If v=0, all strobes are 0.
- Zero latency: strobes are combinational from same-cycle inputs, because the consumer gates with the same cycle's id.
- changeDir = v && enemyDrawReq && wallDrawReq && !dirDone[id]. On a clock where it is 1, dirDone[id] is set.
- dodgeBullet = v && (headsUpDrawReq || headsDownDrawReq) && playerBulletDrawReq && !enemyDrawReq && !dodgeDone[id] && cool[id]==0. On fire: dodgeDone[id] set, cool[id] loaded with DODGE_COOLDOWN_FRAMES.
- shotCollision = (v && enemyDrawReq && playerBulletDrawReq && !hitDone[id]) ? max(bulletDamage,1) : 0. On fire: hitDone[id] set; HP[id] = HP[id] - damage, saturating at 0.
- When HP reaches 0: aliveMap[id] cleared next edge; killCount +1, saturating at 255. allKilled is registered one cycle after aliveMap becomes 0.
- Body hit overrides dodge: dodgeBullet is 0 whenever enemyDrawReq=1. changeDir and shotCollision may fire in the same cycle.
- startOfFrame edge: dirDone, dodgeDone and hitDone all cleared; each nonzero cool[i] decrements by 1. A flag set in the same cycle wins over the clear. Cooldowns do not decrement while pause=1. Flags still clear while paused.
- Pause: all strobes 0. HP, alive state and counters frozen.
- Reset asserted mid-frame: full reinit on that edge; outputs 0 until deassert.
- Id out of range: strobes 0, no state change.

Optional Feature:
ENEMY_RESPAWN_EN
- Defined: each enemy has a frame counter loaded with RESPAWN_FRAMES on death. It decrements on each unpaused startOfFrame. When it reaches 0: aliveMap[i] set, HP[i]=ENEMY_HP, flags and cooldown cleared. Respawn does not change killCount. allKilled deasserts one cycle after any respawn.
- Undefined: dead enemies stay dead until reset. No respawn counters are synthesised.

Test Plan:
- Reset, then id=1, enemyDrawReq=1, wallDrawReq=1 for 3 cycles -> changeDir=1 in first cycle only; after startOfFrame, the same stimulus gives changeDir=1 again.
- id=0, bulletDamage=0, body+bullet overlap over 3 frames -> shotCollision=1 once per frame; aliveMap=2'b10 after 3rd hit, killCount=1.
- id=1, headsUpDrawReq=1 + bullet; DODGE_COOLDOWN_FRAMES=4 -> dodgeBullet=1; repeats in frames 1-4 give 0; frame 5 gives 1.
- pause=1 during body+bullet and wall overlaps -> all strobes 0, HP unchanged; after pause=0 and next startOfFrame, events fire.
- id=5 with AMOUNT_OF_ENEMIES=2, all requests high -> all strobes 0, no state change. Kill both enemies (bulletDamage=7) -> allKilled=1 one cycle after aliveMap=0.
- ENEMY_RESPAWN_EN, RESPAWN_FRAMES=2: kill enemy 0, send 2 startOfFrame pulses -> aliveMap[0]=1, HP restored to 3, killCount stays 1.
